// File: rtl/ram_bus_arbiter_pkg.sv
// ram_bus_arbiter_pkg
//   Shared definitions for the RAM/IO bus arbiter: FSM state encodings,
//   transfer owner, the I/O region selector and the byte-count codes.
package ram_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_READ    = 2'd1,
    ST_WRITE   = 2'd2,
    ST_IO_WAIT = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Address bits [17:16] equal to this value select the I/O region.
  localparam logic [1:0] IO_SEL = 2'b11;

  localparam logic [2:0] NB_1 = 3'd1;
  localparam logic [2:0] NB_2 = 3'd2;
  localparam logic [2:0] NB_4 = 3'd4;

  // Any code other than 1 or 2 is treated as a full word.
  function automatic logic [2:0] decode_nbytes(input logic [2:0] code);
    case (code)
      NB_1:    decode_nbytes = NB_1;
      NB_2:    decode_nbytes = NB_2;
      default: decode_nbytes = NB_4;
    endcase
  endfunction

  function automatic logic [31:0] byte_mask(input logic [2:0] nbytes);
    case (nbytes)
      NB_1:    byte_mask = 32'h0000_00ff;
      NB_2:    byte_mask = 32'h0000_ffff;
      default: byte_mask = 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/ram_bus_arbiter_byte_assembler.sv
// ram_bus_arbiter_byte_assembler
//   Collects read bytes little-endian into a 32-bit buffer. The word output
//   already merges the byte currently on din at position idx, so the final
//   byte of a transfer can be registered by the parent on the same edge it
//   arrives. Bytes above nbytes are forced to zero.
// Ports
//   clk, rst   clock, async active-low reset
//   rdy        global ready; low holds the buffer
//   clear      zero the buffer (start of a read)
//   capture    store din into byte lane idx
//   idx        byte lane 0..3
//   din        read byte from the bus
//   nbytes     transfer size 1/2/4 used for zero fill
//   word       assembled, zero-filled word (combinational)
module ram_bus_arbiter_byte_assembler
  import ram_bus_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        clear,
  input  logic        capture,
  input  logic [1:0]  idx,
  input  logic [7:0]  din,
  input  logic [2:0]  nbytes,
  output logic [31:0] word
);

  logic [31:0] buffer;
  logic [31:0] merged;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      buffer <= '0;
    end else if (rdy) begin
      if (clear) begin
        buffer <= '0;
      end else if (capture) begin
        buffer[{idx, 3'b000} +: 8] <= din;
      end
    end
  end

  always_comb begin
    merged = buffer;
    merged[{idx, 3'b000} +: 8] = din;
    word = merged & byte_mask(nbytes);
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// ram_bus_arbiter
//   Arbitrates instruction fetches (IF) and loads/stores (MEM) onto an 8-bit
//   RAM/IO bus. MEM wins over IF; an active transfer is never preempted.
//   Each access is split into 1/2/4 single-byte cycles (little-endian); the
//   assembled word is returned with a one-cycle done pulse. Writes to the
//   I/O region wait for io_buffer_full to clear and keep at least IO_GAP
//   idle cycles between bytes.
// Ports
//   clk, rst                 clock, async active-low reset
//   rdy                      global ready; low freezes every register
//   if_request/if_addr       IF fetch request (level) and address
//   if_inst_i/if_enable      fetched word and its done pulse
//   load_or_not/store_or_not MEM load/store requests (level)
//   mem_addr/num_of_bytes    MEM byte address and size (1/2/4)
//   store_data               store data, byte 0 in [7:0]
//   load_data/mem_enable     loaded word (zero-filled) and its done pulse
//   io_buffer_full           UART tx buffer full
//   mem_din                  read byte for the address currently on mem_a
//   mem_dout/mem_a/mem_wr    registered bus write data, address, write strobe
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transfer; arbitrate when no done pulse is high
// ST_READ    | capturing one byte per cycle until n bytes are in
// ST_WRITE   | a byte is on the bus with mem_wr=1
// ST_IO_WAIT | I/O write paused (buffer full or gap running), mem_wr=0
module ram_bus_arbiter
  import ram_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IO_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_request,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_inst_i,
  output logic              if_enable,
  input  logic              load_or_not,
  input  logic              store_or_not,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        num_of_bytes,
  input  logic [31:0]       store_data,
  output logic [31:0]       load_data,
  output logic              mem_enable,
  input  logic              io_buffer_full,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  localparam int GAP_W = (IO_GAP < 2) ? 1 : $clog2(IO_GAP + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IO_GAP);

  arb_state_e        state, state_nxt;
  owner_e            owner, owner_nxt;
  logic [1:0]        cnt, cnt_nxt;
  logic [2:0]        nbytes, nbytes_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic              is_io, is_io_nxt;
  logic [GAP_W-1:0]  gap, gap_nxt;
  logic [ADDR_W-1:0] mem_a_nxt;
  logic              mem_wr_nxt;
  logic [7:0]        mem_dout_nxt;
  logic [31:0]       if_inst_nxt, load_data_nxt;
  logic              if_en_nxt, mem_en_nxt;
  logic              asm_clear, asm_capture;
  logic [31:0]       asm_word;
  logic [2:0]        cnt_plus;
  logic              io_blocked;

  assign cnt_plus   = {1'b0, cnt} + 3'd1;
  assign io_blocked = io_buffer_full || (gap != '0);

  ram_bus_arbiter_byte_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .rdy     (rdy),
    .clear   (asm_clear),
    .capture (asm_capture),
    .idx     (cnt),
    .din     (mem_din),
    .nbytes  (nbytes),
    .word    (asm_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    cnt_nxt       = cnt;
    nbytes_nxt    = nbytes;
    wdata_nxt     = wdata;
    is_io_nxt     = is_io;
    gap_nxt       = (gap != '0) ? gap - GAP_W'(1) : gap;
    mem_a_nxt     = mem_a;
    mem_wr_nxt    = mem_wr;
    mem_dout_nxt  = mem_dout;
    if_inst_nxt   = if_inst_i;
    load_data_nxt = load_data;
    if_en_nxt     = 1'b0;
    mem_en_nxt    = 1'b0;
    asm_clear     = 1'b0;
    asm_capture   = 1'b0;

    case (state)
      ST_IDLE: begin
        // The requester drops its level during its done pulse, so nothing
        // is accepted in that cycle.
        if (!(if_enable || mem_enable)) begin
          if (store_or_not) begin
            owner_nxt  = OWN_MEM;
            nbytes_nxt = decode_nbytes(num_of_bytes);
            wdata_nxt  = store_data;
            is_io_nxt  = (mem_addr[17:16] == IO_SEL);
            mem_a_nxt  = mem_addr;
            cnt_nxt    = 2'd0;
            if ((mem_addr[17:16] == IO_SEL) && io_blocked) begin
              state_nxt  = ST_IO_WAIT;
              mem_wr_nxt = 1'b0;
            end else begin
              state_nxt    = ST_WRITE;
              mem_wr_nxt   = 1'b1;
              mem_dout_nxt = store_data[7:0];
              if (mem_addr[17:16] == IO_SEL) gap_nxt = GAP_LOAD;
            end
          end else if (load_or_not) begin
            owner_nxt  = OWN_MEM;
            nbytes_nxt = decode_nbytes(num_of_bytes);
            is_io_nxt  = 1'b0;
            mem_a_nxt  = mem_addr;
            cnt_nxt    = 2'd0;
            mem_wr_nxt = 1'b0;
            asm_clear  = 1'b1;
            state_nxt  = ST_READ;
          end else if (if_request) begin
            owner_nxt  = OWN_IF;
            nbytes_nxt = NB_4;
            is_io_nxt  = 1'b0;
            mem_a_nxt  = if_addr;
            cnt_nxt    = 2'd0;
            mem_wr_nxt = 1'b0;
            asm_clear  = 1'b1;
            state_nxt  = ST_READ;
          end
        end
      end

      ST_READ: begin
        asm_capture = 1'b1;
        if (cnt_plus < nbytes) begin
          mem_a_nxt = mem_a + ADDR_W'(1);
          cnt_nxt   = cnt_plus[1:0];
        end else begin
          state_nxt = ST_IDLE;
          if (owner == OWN_IF) begin
            if_inst_nxt = asm_word;
            if_en_nxt   = 1'b1;
          end else begin
            load_data_nxt = asm_word;
            mem_en_nxt    = 1'b1;
          end
        end
      end

      ST_WRITE: begin
        if (cnt_plus < nbytes) begin
          mem_a_nxt = mem_a + ADDR_W'(1);
          cnt_nxt   = cnt_plus[1:0];
          if (is_io && io_blocked) begin
            state_nxt  = ST_IO_WAIT;
            mem_wr_nxt = 1'b0;
          end else begin
            mem_wr_nxt   = 1'b1;
            mem_dout_nxt = wdata[{cnt_plus[1:0], 3'b000} +: 8];
            if (is_io) gap_nxt = GAP_LOAD;
          end
        end else begin
          mem_wr_nxt = 1'b0;
          mem_en_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end

      ST_IO_WAIT: begin
        // mem_a and cnt already point at the pending byte.
        if (!io_blocked) begin
          state_nxt    = ST_WRITE;
          mem_wr_nxt   = 1'b1;
          mem_dout_nxt = wdata[{cnt, 3'b000} +: 8];
          gap_nxt      = GAP_LOAD;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner      <= OWN_IF;
      cnt        <= '0;
      nbytes     <= NB_4;
      wdata      <= '0;
      is_io      <= 1'b0;
      gap        <= '0;
      mem_a      <= '0;
      mem_wr     <= 1'b0;
      mem_dout   <= '0;
      if_inst_i  <= '0;
      load_data  <= '0;
      if_enable  <= 1'b0;
      mem_enable <= 1'b0;
    end else if (rdy) begin
      owner      <= owner_nxt;
      cnt        <= cnt_nxt;
      nbytes     <= nbytes_nxt;
      wdata      <= wdata_nxt;
      is_io      <= is_io_nxt;
      gap        <= gap_nxt;
      mem_a      <= mem_a_nxt;
      mem_wr     <= mem_wr_nxt;
      mem_dout   <= mem_dout_nxt;
      if_inst_i  <= if_inst_nxt;
      load_data  <= load_data_nxt;
      if_enable  <= if_en_nxt;
      mem_enable <= mem_en_nxt;
    end
  end

endmodule

// File: tb/tb_ram_bus_arbiter.sv
module tb_ram_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        if_request = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_inst_i;
  logic        if_enable;
  logic        load_or_not = 1'b0;
  logic        store_or_not = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [2:0]  num_of_bytes = 3'd4;
  logic [31:0] store_data = '0;
  logic [31:0] load_data;
  logic        mem_enable;
  logic        io_buffer_full = 1'b0;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  always #5 clk = ~clk;

  ram_bus_arbiter #(.ADDR_W(32), .IO_GAP(1)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .if_request     (if_request),
    .if_addr        (if_addr),
    .if_inst_i      (if_inst_i),
    .if_enable      (if_enable),
    .load_or_not    (load_or_not),
    .store_or_not   (store_or_not),
    .mem_addr       (mem_addr),
    .num_of_bytes   (num_of_bytes),
    .store_data     (store_data),
    .load_data      (load_data),
    .mem_enable     (mem_enable),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr)
  );

  // RAM model: combinational read of the registered address, write on edge.
  logic [7:0] ram [0:1023];
  assign mem_din = ram[mem_a[9:0]];

  always @(posedge clk) begin
    if (!rst) begin
      ram[10'h010] = 8'h13; ram[10'h011] = 8'h05;
      ram[10'h012] = 8'h00; ram[10'h013] = 8'h00;
      ram[10'h104] = 8'haa; ram[10'h105] = 8'hbb;
      ram[10'h3fe] = 8'h11; ram[10'h3ff] = 8'h22;
      ram[10'h000] = 8'h33; ram[10'h001] = 8'h44;
      ram[10'h020] = 8'h78; ram[10'h021] = 8'h56;
      ram[10'h022] = 8'h34; ram[10'h023] = 8'h12;
    end else if (rdy && mem_wr) begin
      ram[mem_a[9:0]] = mem_dout;
    end
  end

  typedef struct {
    bit          is_mem;
    bit          chk_data;
    logic [31:0] data;
  } done_t;

  typedef struct {
    logic [31:0] a;
    logic [7:0]  d;
  } wr_t;

  done_t done_q[$];
  wr_t   wr_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: a done pulse or bus write is consumed at the next edge with rdy=1.
  always @(negedge clk) begin
    if (rst && rdy) begin
      if (if_enable && mem_enable) chk("done_exclusive", 32'd1, 32'd0);
      if (if_enable || mem_enable) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", {31'd0, mem_enable}, {31'd0, if_enable});
          chk("unexpected_done_q", 32'd1, 32'd0);
        end else begin
          done_t e;
          e = done_q.pop_front();
          chk("done_owner", {31'd0, mem_enable}, {31'd0, e.is_mem});
          if (e.chk_data) chk("done_data", mem_enable ? load_data : if_inst_i, e.data);
        end
      end
      if (mem_wr) begin
        if (wr_q.size() == 0) begin
          chk("unexpected_write", mem_a, 32'hffff_ffff);
        end else begin
          wr_t w;
          w = wr_q.pop_front();
          chk("wr_addr", mem_a, w.a);
          chk("wr_data", {24'd0, mem_dout}, {24'd0, w.d});
        end
      end
    end
  end

  logic [31:0] a_log [0:31];
  logic        w_log [0:31];
  int          t_if, t_mem;

  // Runs requests already driven until each is answered; iteration i is
  // sampled 1 time unit after the i-th edge following the request (E(i-1)).
  task automatic run(input int budget, input int rdy_lo_at, input int rdy_lo_len,
                     input int full_clr_at);
    t_if  = -1;
    t_mem = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk); #1;
      if (i < 32) begin
        a_log[i] = mem_a;
        w_log[i] = mem_wr;
      end
      if (i == rdy_lo_at) rdy = 1'b0;
      if (rdy_lo_at > 0 && i == rdy_lo_at + rdy_lo_len) rdy = 1'b1;
      if (i == full_clr_at) io_buffer_full = 1'b0;
      if (if_enable && if_request && t_if < 0) begin
        t_if = i;
        if_request = 1'b0;
      end
      if (mem_enable && (load_or_not || store_or_not) && t_mem < 0) begin
        t_mem = i;
        load_or_not = 1'b0;
        store_or_not = 1'b0;
      end
      if (!if_request && !load_or_not && !store_or_not) break;
    end
    if (if_request || load_or_not || store_or_not) begin
      chk("timeout", {29'd0, if_request, load_or_not, store_or_not}, 32'd0);
      if_request = 1'b0;
      load_or_not = 1'b0;
      store_or_not = 1'b0;
    end
    rdy = 1'b1;
    io_buffer_full = 1'b0;
    @(posedge clk); @(posedge clk); #1;
  endtask

  task automatic push_done(input bit is_mem, input bit chk_data, input logic [31:0] d);
    done_t e;
    e.is_mem = is_mem; e.chk_data = chk_data; e.data = d;
    done_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] d);
    wr_t w;
    w.a = a; w.d = d;
    wr_q.push_back(w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    chk("rst_if_inst", if_inst_i, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_pulses", {30'd0, if_enable, mem_enable}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    // 4-byte fetch from 0x10
    push_done(1'b0, 1'b1, 32'h0000_0513);
    if_addr = 32'h10; if_request = 1'b1;
    run(20, 0, 0, 0);
    chk("fetch_latency", t_if, 32'd5);
    for (int k = 1; k <= 4; k++) chk("fetch_addr", a_log[k], 32'h10 + k - 1);

    // MEM load n=2 and IF fetch together: MEM first, IF after
    push_done(1'b1, 1'b1, 32'h0000_bbaa);
    push_done(1'b0, 1'b1, 32'h0000_0513);
    load_or_not = 1'b1; mem_addr = 32'h104; num_of_bytes = 3'd2;
    if_request = 1'b1; if_addr = 32'h10;
    run(30, 0, 0, 0);
    chk("prio_mem_latency", t_mem, 32'd3);
    chk("prio_if_latency", t_if, 32'd9);

    // 1-byte load: zero fill above byte 0
    push_done(1'b1, 1'b1, 32'h0000_00aa);
    load_or_not = 1'b1; mem_addr = 32'h104; num_of_bytes = 3'd1;
    run(20, 0, 0, 0);
    chk("load1_latency", t_mem, 32'd2);

    // Address wraps modulo 2^32
    push_done(1'b0, 1'b1, 32'h4433_2211);
    if_request = 1'b1; if_addr = 32'hffff_fffe;
    run(20, 0, 0, 0);
    chk("wrap_latency", t_if, 32'd5);
    chk("wrap_addr", a_log[3], 32'h0);

    // 4-byte RAM store
    push_wr(32'h200, 8'hef); push_wr(32'h201, 8'hbe);
    push_wr(32'h202, 8'had); push_wr(32'h203, 8'hde);
    push_done(1'b1, 1'b0, 32'h0);
    store_or_not = 1'b1; mem_addr = 32'h200; num_of_bytes = 3'd4;
    store_data = 32'hdead_beef;
    run(20, 0, 0, 0);
    chk("store4_latency", t_mem, 32'd5);

    // 1-byte I/O store held off by io_buffer_full
    push_wr(32'h3_0000, 8'h41);
    push_done(1'b1, 1'b0, 32'h0);
    store_or_not = 1'b1; mem_addr = 32'h3_0000; num_of_bytes = 3'd1;
    store_data = 32'h0000_0041; io_buffer_full = 1'b1;
    run(30, 0, 0, 5);
    chk("io_full_latency", t_mem, 32'd7);
    chk("io_full_wr_low", {31'd0, w_log[5]}, 32'd0);
    chk("io_full_wr_high", {31'd0, w_log[6]}, 32'd1);

    // 2-byte I/O store: one idle cycle between bytes
    push_wr(32'h3_0000, 8'h41); push_wr(32'h3_0001, 8'h42);
    push_done(1'b1, 1'b0, 32'h0);
    store_or_not = 1'b1; mem_addr = 32'h3_0000; num_of_bytes = 3'd2;
    store_data = 32'h0000_4241;
    run(30, 0, 0, 0);
    chk("io_gap_latency", t_mem, 32'd4);
    chk("io_gap_pattern", {29'd0, w_log[1], w_log[2], w_log[3]}, 32'b101);

    // rdy low for 3 cycles mid fetch
    push_done(1'b0, 1'b1, 32'h1234_5678);
    if_request = 1'b1; if_addr = 32'h20;
    run(30, 2, 3, 0);
    chk("rdy_latency", t_if, 32'd8);
    chk("rdy_frozen_addr", a_log[5], 32'h21);

    // Reset mid store: only the first byte reaches the bus, no done pulse
    push_wr(32'h280, 8'h44);
    store_or_not = 1'b1; mem_addr = 32'h280; num_of_bytes = 3'd4;
    store_data = 32'h1122_3344;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    store_or_not = 1'b0;
    #1;
    chk("midrst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("midrst_mem_en", {31'd0, mem_enable}, 32'd0);
    chk("midrst_load_data", load_data, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Next request served normally from IDLE (reads back the earlier store)
    push_done(1'b1, 1'b1, 32'hdead_beef);
    load_or_not = 1'b1; mem_addr = 32'h200; num_of_bytes = 3'd4;
    run(20, 0, 0, 0);
    chk("post_rst_latency", t_mem, 32'd5);

    repeat (3) @(posedge clk);
    #1;
    chk("done_q_empty", done_q.size(), 32'd0);
    chk("wr_q_empty", wr_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
